// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- RV32I integer register file (x0..x31), feeds the ALU operand muxes.
//
// Purpose
//   Two asynchronous read ports and one synchronous write port. x0 is hardwired
//   to zero. It has no storage, and reads of address 0 always return 0.
//   A synchronous, active-high reset clears every register. While rst is held,
//   both read ports return 0.
//
// Ports
//   clk       in   1       core clock, all state updates on the rising edge
//   rst       in   1       synchronous active-high reset (has priority over writes)
//   rs1_addr  in   ADDR_W  read port 1 address
//   rs2_addr  in   ADDR_W  read port 2 address
//   rs1_data  out  WIDTH   read port 1 data (ALU in_a path)
//   rs2_data  out  WIDTH   read port 2 data (ALU in_b path)
//   rd_we     in   1       write enable
//   rd_addr   in   ADDR_W  write address (address 0 discards the write)
//   rd_data   in   WIDTH   write data
//
// Configuration
//   RF_BYPASS_EN  When defined, a read of the register being written in the
//                 same cycle returns rd_data combinationally. The array is
//                 still written at the edge.
//                 When undefined (the default, used by the single-cycle core),
//                 a same-cycle read returns the old stored value.
//
// There is no handshake. Reads are pure combinational lookups, and a write
// commits on every rising edge where rd_we=1, rst=0 and rd_addr != 0.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage exists only for x1..x(DEPTH-1). Leaving out x0 guarantees that it
    // can never hold a non-zero value.
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs[g] <= '0;
            end else if (rd_we && (rd_addr == ADDR_W'(g))) begin
                regs[g] <= rd_data;
            end
        end
    end

    // Shared read rule for both ports. The order of checks is:
    // reset, then x0, then the optional bypass, then the stored value.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (rst || (a == '0)) begin
            v = '0;
        end
`ifdef RF_BYPASS_EN
        else if (rd_we && (rd_addr == a)) begin
            // Address 0 was already handled above, so the bypass never
            // forwards to x0.
            v = rd_data;
        end
`endif
        else begin
            v = regs[a];
        end
        return v;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file.
//
// The driver applies one set of inputs per cycle. It predicts both read ports
// from an array model of the architectural registers and pushes those
// predictions into exp_q. The monitor pops and compares them at the falling
// edge. The model is advanced after each rising edge, using the inputs that
// were present at that edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [W-1:0]  rs1_data, rs2_data, rd_data;
  logic          rd_we;

  reg_file #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [W-1:0]   model [N];
  logic [2*W-1:0] exp_q [$];
  string          tag_q [$];
  int             total = 0;
  int             bad   = 0;

  function automatic logic [W-1:0] ref_read(input logic r, input logic we,
                                            input int wa, input logic [W-1:0] wd,
                                            input int ra);
    if (r || ra == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return model[ra];
  endfunction

  // driver: one cycle of stimulus, expected reads pushed, model advanced at edge
  task automatic cycle(input logic r, input logic we, input int wa,
                       input logic [W-1:0] wd, input int ra1, input int ra2,
                       input string tag);
    rst      = r;
    rd_we    = we;
    rd_addr  = AW'(wa);
    rd_data  = wd;
    rs1_addr = AW'(ra1);
    rs2_addr = AW'(ra2);
    exp_q.push_back({ref_read(r, we, wa, wd, ra1), ref_read(r, we, wa, wd, ra2)});
    tag_q.push_back(tag);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic rd(input int ra1, input int ra2, input string tag);
    cycle(1'b0, 1'b0, 0, W'($urandom), ra1, ra2, tag);
  endtask

  task automatic wr(input int wa, input logic [W-1:0] wd, input string tag);
    cycle(1'b0, 1'b1, wa, wd, int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)), tag);
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2*W-1:0] e;
      string          t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (rs1_data !== e[2*W-1:W]) begin
        bad++;
        $display("FAIL %s rs1 addr=%0d got=%h want=%h", t, rs1_addr, rs1_data, e[2*W-1:W]);
      end
      total++;
      if (rs2_data !== e[W-1:0]) begin
        bad++;
        $display("FAIL %s rs2 addr=%0d got=%h want=%h", t, rs2_addr, rs2_data, e[W-1:0]);
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // stimulus
  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;
    rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
    @(posedge clk); #1;

    // reset state
    cycle(1'b1, 1'b0, 0, '0, 5, 31, "reset_hold");
    cycle(1'b1, 1'b0, 0, '0, 1, 17, "reset_hold2");
    rd(5, 31, "reset_state");

    // 1: reset clears a written register
    wr(5, 32'hDEADBEEF, "t1_write");
    rd(5, 0, "t1_before_rst");
    cycle(1'b1, 1'b0, 0, '0, 5, 5, "t1_rst");
    rd(5, 5, "t1_after_rst");

    // 2: write then read from both ports
    wr(7, 32'h12345678, "t2_write");
    rd(7, 7, "t2_both");
    rd(8, 7, "t2_x8");

    // 3: writes to x0 are discarded
    cycle(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0, "t3_write_x0");
    rd(0, 0, "t3_x0");
    rd(0, 7, "t3_x0_later");

    // 4: same-cycle read-after-write
    wr(3, 32'hA, "t4_init");
    cycle(1'b0, 1'b1, 3, 32'hB, 3, 3, "t4_raw_same");
    rd(3, 3, "t4_raw_next");
    cycle(1'b0, 1'b1, 0, 32'h77, 0, 0, "t4_no_fwd_x0");

    // 5: reset wins over a simultaneous write
    cycle(1'b1, 1'b1, 9, 32'h55, 9, 3, "t5_rst_wr");
    rd(9, 3, "t5_after");

    // 6: sweep
    for (int i = 1; i < N; i++) wr(i, W'((i << 8) | i), "t6_write");
    for (int i = 0; i < N; i++) rd(i, N - 1 - i, "t6_pairs");

    // random traffic, biased toward read-after-write hits
    for (int k = 0; k < 400; k++) begin
      logic r, we;
      int   wa, ra1, ra2;
      r   = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 2) != 0);
      wa  = $urandom_range(0, N-1);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, N-1));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, N-1));
      cycle(r, we, wa, W'($urandom), ra1, ra2, "random");
    end

    // drain the scoreboard (bounded)
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
